dsp_op_sequencer: RTL
=====================

Name: dsp_op_sequencer

Overview:
- Initiator-side controller for the DSP_top multiply/MAC datapath.
- Accepts operation requests on a valid/ready interface and drives the DSP operand/control pins for the 1, 2 or 4 cycles the selected mode needs.
- Samples the DSP result at the correct latency and returns it through a small result FIFO with valid/ready backpressure.
- Sits between the instruction/stream front end and DSP_top.

Parameters:
- N, 16, width of operand a.
- M, 16, width of operand b.
- ADD_LAT, 0, cycles from the last issue cycle to a valid dsp_out (final adder pipe depth).
- RES_DEPTH, 2, result FIFO entries (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_a  input  N  operand a.
- req_b  input  M  operand b.
- req_c  input  N+M  addend, used when req_mac=0.
- req_mode  input  2  0: half x half (1 cycle); 1: N x half (2 cycles); 2: N x M (4 cycles); 3: illegal.
- req_mac  input  1  1 = accumulate onto the previous DSP result.
- req_shift  input  2  accumulator barrel shift applied when req_mac=1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  N+M  result.
- dsp_start, dsp_aa[N], dsp_bb[M], dsp_cc[N+M], dsp_mode[2], dsp_mac, dsp_barrel_shifter[2]  outputs  to DSP_top.
- dsp_out  input  N+M  DSP_top result.
- busy  output  1  op issuing or in flight, or FIFO non-empty.
- err_mode  output  1  one-cycle pulse when a mode-3 request is accepted.

Behaviour:
- Reset: all outputs 0 (req_ready 0 while reset high); FSM to IDLE; FIFO empty; in-flight pipeline cleared. Reset mid-op abandons the op with no result. req_ready rises the first cycle after reset falls.
- Handshake: a transfer happens on a clock edge with req_valid & req_ready. res_data is stable while res_valid & !res_ready.
- Credits: inflight = ops issued but not yet written to the FIFO. req_ready = (IDLE or last ISSUE cycle) & (fifo_count + inflight + 1 <= RES_DEPTH). The FIFO pop of the same edge is not counted; no combinational path from res_ready to req_ready.
- FSM states:
  - IDLE: on accept of mode 0–2, load dsp_* registers and go to ISSUE with cnt = cycles-1.
  - ISSUE: dsp_start=1 only in the first cycle. dsp_aa, dsp_bb, dsp_cc, dsp_mode, dsp_mac and dsp_barrel_shifter are held constant for every cycle of the op. cnt decrements each cycle.
  - Last ISSUE cycle (cnt=0): accept a new request (back-to-back; its start lands the next cycle) or return to IDLE.
- Mode 3: accepted, no DSP cycles, dsp_start stays 0, err_mode pulses the next cycle, nothing enters the FIFO or the credit count.
- Capture: a valid bit enters a delay line of depth ADD_LAT at the last ISSUE cycle. When it emerges (ADD_LAT=0: the same last cycle), dsp_out is written to the FIFO on that edge.
- Latency: with ADD_LAT=0 and an empty FIFO, res_valid rises 1+cycles(mode) edges after the accept edge (mode 0: 2, mode 1: 3, mode 2: 5).
- Ordering: results leave strictly in issue order.
- FIFO: simultaneous push and pop allowed when full or empty; overflow cannot occur because of the credit check.
- MAC: a mac=1 op issued back-to-back uses the DSP internal carry-save state. The sequencer does not check that a prior op exists. dsp_cc is driven 0 when mac=1.
- Idle drive: outside ISSUE, dsp_start=0 and the other dsp_* outputs hold their last value.

Decomposition:
- Shared package holds:
  - mode encodings MODE_HALF=0, MODE_WIDE_B=1, MODE_FULL=2;
  - the cycles-per-mode function (1, 2, 4);
  - FSM state constants.
- Sub-module sync_fifo (width N+M, depth RES_DEPTH, count output) holds the results. The delay line stays inline.

Test Plan:
- Mode 0: a=5, b=7, c=3, mac=0, res_ready=1 -> one dsp_start pulse; res_data=38 two edges after accept.
- Mode 2: a=0x1234, b=0x0010, c=0 -> dsp_start high 1 cycle; dsp_aa/dsp_bb stable 4 cycles; res_data=0x00012340 five edges after accept.
- Back-to-back: mode 1 then mode 0 with req_valid held -> second dsp_start exactly 2 cycles after the first; results arrive in order.
- Backpressure: res_ready=0, three mode-0 requests -> two accepted, req_ready low until one pop, then the third is accepted; no result lost.
- Illegal: req_mode=3 -> accepted, err_mode pulses once, dsp_start stays 0, no res_valid.
- Reset during cycle 2 of a mode-2 op -> all outputs 0 next cycle; no result ever emitted; next mode-0 op computes correctly.

Source files
------------

// File: rtl/dsp_op_sequencer_pkg.sv
// Shared encodings for the DSP operation sequencer: mode codes, FSM states
// and the number of DSP issue cycles each mode occupies.
package dsp_op_sequencer_pkg;

  localparam logic [1:0] MODE_HALF    = 2'd0;
  localparam logic [1:0] MODE_WIDE_B  = 2'd1;
  localparam logic [1:0] MODE_FULL    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Illegal mode occupies no DSP cycles.
  function automatic logic [2:0] mode_cycles(input logic [1:0] mode);
    case (mode)
      MODE_HALF:   return 3'd1;
      MODE_WIDE_B: return 3'd2;
      MODE_FULL:   return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dsp_op_sequencer_sync_fifo.sv
// Result FIFO: array storage with a registered read into an output stage, so a
// pushed word becomes visible one edge after the push.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic                         pop_valid_o,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    mem_cnt_q, count_q;
  logic [WIDTH-1:0] out_q;
  logic             out_vld_q;
  logic             pop_eff, load;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_eff = pop_i & out_vld_q;
  // Refill the output stage whenever it is empty or being drained this edge.
  assign load    = (mem_cnt_q != '0) && (!out_vld_q || pop_eff);

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (load) begin
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
        out_q     <= mem_q[rd_ptr_q];
        out_vld_q <= 1'b1;
      end else if (pop_eff) begin
        out_vld_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + CW'(push_i) - CW'(load);
      count_q   <= count_q + CW'(push_i) - CW'(pop_eff);
    end
  end

  assign pop_valid_o = out_vld_q;
  assign pop_data_o  = out_vld_q ? out_q : '0;
  assign count_o     = count_q;

endmodule

// File: rtl/dsp_op_sequencer.sv
// Initiator-side sequencer for the DSP multiply/MAC datapath: issues operand
// bursts, captures dsp_out at the configured latency and queues results.
module dsp_op_sequencer
  import dsp_op_sequencer_pkg::*;
#(
  parameter int N         = 16,
  parameter int M         = 16,
  parameter int ADD_LAT   = 0,
  parameter int RES_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [N-1:0]   req_a,
  input  logic [M-1:0]   req_b,
  input  logic [N+M-1:0] req_c,
  input  logic [1:0]     req_mode,
  input  logic           req_mac,
  input  logic [1:0]     req_shift,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N+M-1:0] res_data,
  output logic           dsp_start,
  output logic [N-1:0]   dsp_aa,
  output logic [M-1:0]   dsp_bb,
  output logic [N+M-1:0] dsp_cc,
  output logic [1:0]     dsp_mode,
  output logic           dsp_mac,
  output logic [1:0]     dsp_barrel_shifter,
  input  logic [N+M-1:0] dsp_out,
  output logic           busy,
  output logic           err_mode
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [CW-1:0]  inflight_q, fifo_count;
  logic [CW:0]    need;
  logic           accept, legal, issue_last, credit_ok, push, pop;
  logic           start_q, err_q;

  assign issue_last = (state_q == ST_ISSUE) && (cnt_q == 2'd0);
  // Credits are checked against the registered count only; this edge's pop
  // is ignored so res_ready never reaches req_ready combinationally.
  assign need       = {1'b0, fifo_count} + {1'b0, inflight_q} + (CW+1)'(1);
  assign credit_ok  = need <= (CW+1)'(RES_DEPTH);
  assign req_ready  = !reset && ((state_q == ST_IDLE) || issue_last) && credit_ok;
  assign accept     = req_valid & req_ready;
  assign legal      = accept && (req_mode != MODE_ILLEGAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_ISSUE) begin
      cnt_d = cnt_q - 2'd1;
      if (cnt_q == 2'd0) begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    end
    if (legal) begin
      state_d = ST_ISSUE;
      cnt_d   = 2'(mode_cycles(req_mode) - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      cnt_q              <= 2'd0;
      start_q            <= 1'b0;
      err_q              <= 1'b0;
      dsp_aa             <= '0;
      dsp_bb             <= '0;
      dsp_cc             <= '0;
      dsp_mode           <= 2'd0;
      dsp_mac            <= 1'b0;
      dsp_barrel_shifter <= 2'd0;
      inflight_q         <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= legal;
      err_q      <= accept && (req_mode == MODE_ILLEGAL);
      inflight_q <= inflight_q + CW'(legal) - CW'(push);
      if (legal) begin
        dsp_aa             <= req_a;
        dsp_bb             <= req_b;
        dsp_cc             <= req_mac ? '0 : req_c;
        dsp_mode           <= req_mode;
        dsp_mac            <= req_mac;
        dsp_barrel_shifter <= req_shift;
      end
    end
  end

  // Capture strobe follows the last issue cycle through the adder pipe depth.
  if (ADD_LAT == 0) begin : g_direct
    assign push = issue_last;
  end else begin : g_delay
    logic [ADD_LAT-1:0] dly_q;
    for (genvar gi = 0; gi < ADD_LAT; gi++) begin : g_stage
      logic stage_in;
      if (gi == 0) begin : g_first
        assign stage_in = issue_last;
      end else begin : g_next
        assign stage_in = dly_q[gi-1];
      end
      always_ff @(posedge clk) begin
        if (reset) dly_q[gi] <= 1'b0;
        else       dly_q[gi] <= stage_in;
      end
    end
    assign push = dly_q[ADD_LAT-1];
  end

  assign pop = res_valid & res_ready;

  sync_fifo #(
    .WIDTH(N + M),
    .DEPTH(RES_DEPTH)
  ) u_res_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(dsp_out),
    .pop_i      (pop),
    .pop_valid_o(res_valid),
    .pop_data_o (res_data),
    .count_o    (fifo_count)
  );

  assign dsp_start = start_q;
  assign err_mode  = err_q;
  assign busy      = (state_q == ST_ISSUE) || (inflight_q != '0) || (fifo_count != '0);

endmodule
